wash_timer_ctrl: RTL and testbench



---
 rtl/wash_timer_pkg.sv | 63 ++++++
 rtl/wash_tick_gen.sv | 32 +++
 rtl/wash_timer_ctrl.sv | 139 +++++++++++++
 tb/tb_wash_timer_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_timer_pkg.sv
// Shared types, phase encoding and program duration tables for the wash timer.
// Durations are in timing ticks.
package wash_timer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARMED,
    S_WASH,
    S_WASH_TO,
    S_WAIT_RINSE,
    S_RINSE,
    S_RINSE_TO,
    S_WAIT_SPIN,
    S_SPIN,
    S_SPIN_TO,
    S_FAULT
  } state_t;

  // Status code shown on the phase port; a phase and its timeout share a code.
  typedef enum logic [2:0] {
    PH_IDLE,
    PH_ARMED,
    PH_WASH,
    PH_WAIT_RINSE,
    PH_RINSE,
    PH_WAIT_SPIN,
    PH_SPIN,
    PH_FAULT
  } phase_t;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2
  } prog_t;

  // Entry 3 mirrors normal so any 2-bit index stays in range.
  localparam logic [7:0] WASH_T  [4] = '{8'd20, 8'd40, 8'd60, 8'd40};
  localparam logic [7:0] RINSE_T [4] = '{8'd10, 8'd20, 8'd30, 8'd20};
  localparam logic [7:0] SPIN_T  [4] = '{8'd10, 8'd15, 8'd20, 8'd15};

  function automatic prog_t prog_decode(logic [1:0] sel);
    case (sel)
      2'd0:    return PROG_QUICK;
      2'd2:    return PROG_HEAVY;
      default: return PROG_NORMAL;
    endcase
  endfunction

  function automatic phase_t phase_of(state_t s);
    case (s)
      S_IDLE:                return PH_IDLE;
      S_ARMED:               return PH_ARMED;
      S_WASH, S_WASH_TO:     return PH_WASH;
      S_WAIT_RINSE:          return PH_WAIT_RINSE;
      S_RINSE, S_RINSE_TO:   return PH_RINSE;
      S_WAIT_SPIN:           return PH_WAIT_SPIN;
      S_SPIN, S_SPIN_TO:     return PH_SPIN;
      default:               return PH_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on
// the last count. Held at zero while disabled or restarted.
module wash_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || restart || !en) begin
      pre <= '0;
    end else if (pre == LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  assign tick = en && (pre == LAST);

endmodule

// File: rtl/wash_timer_ctrl.sv
// Program-driven phase timer beside the washer FSM: times wash/rinse/spin,
// returns cycletout/spintout, and trips a sticky fault on an over-long fill.
module wash_timer_ctrl
  import wash_timer_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 1000,
  parameter int FILL_MAX = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] prog_sel,
  input  logic       doorlock,
  input  logic       motoron,
  input  logic       fillvalve,
  input  logic       drained,
  input  logic       done,
  output logic       cycletout,
  output logic       spintout,
  output logic       busy,
  output logic       fault,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] FILL_LIM = CNT_W'(FILL_MAX);

  state_t           state, state_nx;
  prog_t            prog_q;
  logic             doorlock_q, motoron_q;
  logic [CNT_W-1:0] cnt, wd;
  logic [CNT_W-1:0] load_val;
  logic [7:0]       dur_raw;
  logic             load, tick, busy_st, dec_en, fill_trip;

  wire doorlock_rise = doorlock & ~doorlock_q;
  wire motoron_rise  = motoron & ~motoron_q;

  assign busy_st   = (state != S_IDLE) && (state != S_FAULT);
  assign fill_trip = busy_st && (wd == FILL_LIM);
  assign dec_en    = (((state == S_WASH) || (state == S_RINSE)) && motoron)
                     || (state == S_SPIN);

  wash_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (busy_st),
    .restart (load),
    .tick    (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    dur_raw  = '0;
    case (state)
      S_IDLE:       if (doorlock_rise) state_nx = S_ARMED;
      S_ARMED:      if (motoron_rise) begin
                      state_nx = S_WASH;
                      load     = 1'b1;
                      dur_raw  = WASH_T[prog_q];
                    end
      S_WASH:       if (cnt == '0) state_nx = S_WASH_TO;
      S_WASH_TO:    if (!motoron) state_nx = S_WAIT_RINSE;
      S_WAIT_RINSE: if (motoron_rise) begin
                      state_nx = S_RINSE;
                      load     = 1'b1;
                      dur_raw  = RINSE_T[prog_q];
                    end
      S_RINSE:      if (cnt == '0) state_nx = S_RINSE_TO;
      S_RINSE_TO:   if (!motoron) state_nx = S_WAIT_SPIN;
      S_WAIT_SPIN:  if (drained) begin
                      state_nx = S_SPIN;
                      load     = 1'b1;
                      dur_raw  = SPIN_T[prog_q];
                    end
      S_SPIN:       if (cnt == '0) state_nx = S_SPIN_TO;
      S_SPIN_TO:    if (done) state_nx = S_IDLE;
      S_FAULT:      state_nx = S_FAULT;
      default:      state_nx = S_IDLE;
    endcase
    // Fault entry overrides an abort, which overrides the normal sequence.
    if (busy_st && !doorlock) begin
      state_nx = S_IDLE;
      load     = 1'b0;
    end
    if (fill_trip) begin
      state_nx = S_FAULT;
      load     = 1'b0;
    end
  end

  assign load_val = (dur_raw == 8'd0) ? CNT_W'(1) : CNT_W'(dur_raw);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      prog_q     <= PROG_QUICK;
      doorlock_q <= 1'b0;
      motoron_q  <= 1'b0;
      cnt        <= '0;
      wd         <= '0;
    end else begin
      state      <= state_nx;
      doorlock_q <= doorlock;
      motoron_q  <= motoron;
      if (state == S_IDLE && doorlock_rise) prog_q <= prog_decode(prog_sel);
      if (load) begin
        cnt <= load_val;
      end else if (dec_en && tick && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (!fillvalve) begin
        wd <= '0;
      end else if (tick && wd < FILL_LIM) begin
        wd <= wd + CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they change with the state flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycletout <= 1'b0;
      spintout  <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      phase     <= PH_IDLE;
    end else begin
      cycletout <= (state_nx == S_WASH_TO) || (state_nx == S_RINSE_TO);
      spintout  <= (state_nx == S_SPIN_TO);
      busy      <= (state_nx != S_IDLE) && (state_nx != S_FAULT);
      fault     <= (state_nx == S_FAULT);
      phase     <= phase_of(state_nx);
    end
  end

endmodule

// File: tb/tb_wash_timer_ctrl.sv
// Scoreboard bench for wash_timer_ctrl: stimulus queues cycle-stamped expected
// outputs, a negedge monitor pops and compares them as the DUT reaches that cycle.
module tb_wash_timer_ctrl;

  localparam int T = 2;
  localparam logic [2:0] P_ARMED = 3'd1, P_WASH = 3'd2, P_WAIT_RINSE = 3'd3,
                         P_RINSE = 3'd4, P_WAIT_SPIN = 3'd5, P_SPIN = 3'd6,
                         P_FAULT = 3'd7;
  localparam logic [6:0] OV_IDLE  = 7'b0000000;
  localparam logic [6:0] OV_FAULT = {4'b0001, P_FAULT};

  logic       clk, rst;
  logic [1:0] prog_sel;
  logic       doorlock, motoron, fillvalve, drained, done;
  logic       cycletout, spintout, busy, fault;
  logic [2:0] phase;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wash_timer_ctrl #(.CNT_W(16), .TICK_DIV(T), .FILL_MAX(600)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_sel  (prog_sel),
    .doorlock  (doorlock),
    .motoron   (motoron),
    .fillvalve (fillvalve),
    .drained   (drained),
    .done      (done),
    .cycletout (cycletout),
    .spintout  (spintout),
    .busy      (busy),
    .fault     (fault),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output vector layout: {cycletout, spintout, busy, fault, phase}
  function automatic logic [6:0] ov_run(logic [2:0] ph);
    return {4'b0010, ph};
  endfunction
  function automatic logic [6:0] ov_cto(logic [2:0] ph);
    return {4'b1010, ph};
  endfunction
  function automatic logic [6:0] ov_sto();
    return {4'b0110, P_SPIN};
  endfunction

  always @(negedge clk) begin
    logic [6:0] act;
    act = {cycletout, spintout, busy, fault, phase};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_cmp++;
        if (q[i].cyc != cyc || act !== q[i].val) begin
          n_bad++;
          $display("FAIL %s: actual=%b required=%b (cycle %0d, due %0d)",
                   q[i].name, act, q[i].val, cyc, q[i].cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic check(string name, logic [6:0] val);
    logic [6:0] act;
    act = {cycletout, spintout, busy, fault, phase};
    n_cmp++;
    if (act !== val) begin
      n_bad++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, val, cyc);
    end
  endtask

  task automatic expect_out(int dly, string name, logic [6:0] val);
    exp_t e;
    e.cyc  = cyc + dly;
    e.name = name;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm(logic [1:0] prog, string nm);
    doorlock = 1'b0;
    prog_sel = prog;
    step(2);
    doorlock = 1'b1;
    expect_out(1, {nm, "_arm"}, ov_run(P_ARMED));
    step(1);
  endtask

  // Motor-driven phase from ARMED/WAIT_RINSE: load on motoron rise, timeout
  // ticks*T+1 cycles after load (+gap for an even-length motoron dropout).
  task automatic motor_phase(int ticks, logic [2:0] ph_run, logic [2:0] ph_after,
                             int gap, int new_prog, string nm);
    int d;
    d = ticks * T + 2 + gap;
    motoron = 1'b1;
    expect_out(1,     {nm, "_load"}, ov_run(ph_run));
    expect_out(d - 1, {nm, "_pre"},  ov_run(ph_run));
    expect_out(d,     {nm, "_to"},   ov_cto(ph_run));
    expect_out(d + 3, {nm, "_hold"}, ov_cto(ph_run));
    step(10);
    if (new_prog >= 0) prog_sel = new_prog[1:0];
    if (gap > 0) begin
      motoron = 1'b0;
      step(gap);
      motoron = 1'b1;
    end
    step(d + 3 - 10 - gap);
    motoron = 1'b0;
    expect_out(1, {nm, "_exit"}, ov_run(ph_after));
    step(1);
  endtask

  task automatic spin_phase(int ticks, string nm);
    int d;
    d = ticks * T + 2;
    drained = 1'b1;
    expect_out(1,     {nm, "_load"}, ov_run(P_SPIN));
    expect_out(d - 1, {nm, "_pre"},  ov_run(P_SPIN));
    expect_out(d,     {nm, "_to"},   ov_sto());
    expect_out(d + 3, {nm, "_hold"}, ov_sto());
    step(d + 3);
    done = 1'b1;
    expect_out(1, {nm, "_done"}, OV_IDLE);
    step(1);
    done    = 1'b0;
    drained = 1'b0;
    expect_out(2, {nm, "_idle"}, OV_IDLE);
    step(2);
  endtask

  initial begin
    rst = 1'b1; prog_sel = 2'd0; doorlock = 1'b0; motoron = 1'b0;
    fillvalve = 1'b0; drained = 1'b0; done = 1'b0;
    step(2);
    check("reset_now", OV_IDLE);
    expect_out(1, "reset", OV_IDLE);
    step(1);
    rst = 1'b0;
    expect_out(1, "post_reset", OV_IDLE);
    step(1);

    // Quick program; prog_sel moves to heavy mid-wash and must be ignored.
    arm(2'd0, "q");
    motor_phase(20, P_WASH, P_WAIT_RINSE, 0, 2, "q_wash");
    motor_phase(10, P_RINSE, P_WAIT_SPIN, 0, -1, "q_rinse");
    spin_phase(10, "q_spin");

    // prog_sel=3 runs as normal; motoron dropout during wash holds the count.
    arm(2'd3, "n");
    motor_phase(40, P_WASH, P_WAIT_RINSE, 6, -1, "n_wash");
    motor_phase(20, P_RINSE, P_WAIT_SPIN, 0, -1, "n_rinse");
    spin_phase(15, "n_spin");

    // Door opened during rinse aborts to IDLE; a fresh run then works.
    arm(2'd1, "a");
    motor_phase(40, P_WASH, P_WAIT_RINSE, 0, -1, "a_wash");
    motoron = 1'b1;
    expect_out(1, "a_rinse", ov_run(P_RINSE));
    step(5);
    doorlock = 1'b0;
    expect_out(1, "abort", OV_IDLE);
    step(1);
    motoron = 1'b0;
    expect_out(2, "abort_idle", OV_IDLE);
    step(2);
    arm(2'd0, "f");
    motor_phase(20, P_WASH, P_WAIT_RINSE, 0, -1, "f_wash");
    doorlock = 1'b0;
    expect_out(1, "abort2", OV_IDLE);
    step(1);

    // Fill valve held open for 600 ticks trips a sticky fault.
    arm(2'd1, "w");
    fillvalve = 1'b1;
    expect_out(1190, "wd_before", ov_run(P_ARMED));
    expect_out(1215, "wd_fault", OV_FAULT);
    step(1215);
    motoron = 1'b1;
    expect_out(4, "fault_motor", OV_FAULT);
    step(4);
    doorlock = 1'b0;
    expect_out(3, "fault_door0", OV_FAULT);
    step(3);
    doorlock = 1'b1;
    expect_out(3, "fault_door1", OV_FAULT);
    step(3);
    motoron = 1'b0; fillvalve = 1'b0;
    expect_out(3, "fault_sticky", OV_FAULT);
    step(3);
    check("fault_now", OV_FAULT);
    rst = 1'b1; doorlock = 1'b0;
    expect_out(1, "fault_rst", OV_IDLE);
    step(1);
    check("fault_rst_now", OV_IDLE);
    step(1);
    rst = 1'b0;
    step(1);

    // Reset during SPIN_TO clears everything; motoron rise in IDLE is ignored.
    arm(2'd0, "r");
    motor_phase(20, P_WASH, P_WAIT_RINSE, 0, -1, "r_wash");
    motor_phase(10, P_RINSE, P_WAIT_SPIN, 0, -1, "r_rinse");
    drained = 1'b1;
    expect_out(1, "r_spin", ov_run(P_SPIN));
    expect_out(22, "r_spinto", ov_sto());
    step(23);
    rst = 1'b1; doorlock = 1'b0; drained = 1'b0;
    expect_out(1, "rst_spin", OV_IDLE);
    step(1);
    check("rst_spin_now", OV_IDLE);
    rst = 1'b0;
    step(1);
    motoron = 1'b1;
    expect_out(1, "idle_motor1", OV_IDLE);
    expect_out(3, "idle_motor3", OV_IDLE);
    step(3);
    motoron = 1'b0;
    step(3);
    check("final_idle", OV_IDLE);
    n_cmp++;
    if (busy !== 1'b0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL final_flags: busy=%b fault=%b required 0/0", busy, fault);
    end

    foreach (q[i]) begin
      n_bad++;
      $display("FAIL %s: never sampled, required=%b", q[i].name, q[i].val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
